data_reader: RTL

DATA_READER -- requirements
Module: data_reader

---
 rtl/data_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/data_reader.sv
// data_reader: snapshots four register bytes and streams NUM_REGS of them over a valid/ready port; define DATA_READER_CHECKSUM_EN to append a checksum beat
module data_reader #(
  parameter int NUM_REGS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] reg1,
  input  logic [7:0] reg2,
  input  logic [7:0] reg3,
  input  logic [7:0] reg4,
  output logic       hold_req,
  output logic [7:0] out_data,
  output logic [1:0] out_id,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_csum,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, CSUM, DONE} state_t;
  localparam logic [1:0] LAST = 2'(NUM_REGS - 1);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] snap_q [4];
  logic [7:0] snap_d [4];
`ifdef DATA_READER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  // next state and outputs, decoded from the registered state so idle outputs sit at zero
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    snap_d = snap_q;
`ifdef DATA_READER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    hold_req = 1'b0;
    out_valid = 1'b0;
    out_data = 8'd0;
    out_id = 2'd0;
    out_last = 1'b0;
    out_csum = 1'b0;
    busy = state_q != IDLE;
    done = state_q == DONE;
    case (state_q)
      IDLE: state_d = start ? CAPTURE : IDLE;
      CAPTURE: begin
        hold_req = 1'b1;
        snap_d = '{reg1, reg2, reg3, reg4};
        idx_d = 2'd0;
`ifdef DATA_READER_CHECKSUM_EN
        csum_d = 8'd0;
`endif
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data = snap_q[idx_q];
        out_id = idx_q;
`ifdef DATA_READER_CHECKSUM_EN
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          csum_d = csum_q + snap_q[idx_q];
          state_d = idx_q == LAST ? CSUM : SEND;
        end
`else
        out_last = idx_q == LAST;
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          state_d = idx_q == LAST ? DONE : SEND;
        end
`endif
      end
`ifdef DATA_READER_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data = csum_q;
        out_csum = 1'b1;
        out_last = 1'b1;
        state_d = out_ready ? DONE : CSUM;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, index, snapshot and checksum registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      snap_q <= '{default: 8'd0};
`ifdef DATA_READER_CHECKSUM_EN
      csum_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
`ifdef DATA_READER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule
